// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller with edge-latched pending bits,
// mask, fixed priority (lowest index wins), return-address capture and a
// 16-byte register window on the cpu data bus.
// Optional build macro: INT_LEVEL_MODE_EN adds a MODE register (offset 6) that
// makes selected sources level-triggered.
module int_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                N_SRC     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'd224
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    output logic [DATA_W-1:0] r_data,
    output logic              hit,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic              int_req,
    output logic              int_en,
    output logic [ADDR_W-1:0] int_vec
);

    localparam logic [3:0] OFF_CTRL  = 4'd0;
    localparam logic [3:0] OFF_MASK  = 4'd1;
    localparam logic [3:0] OFF_PEND  = 4'd2;
    localparam logic [3:0] OFF_RET   = 4'd3;
    localparam logic [3:0] OFF_CAUSE = 4'd4;
    localparam logic [3:0] OFF_ACK   = 4'd5;
    localparam logic [3:0] OFF_MODE  = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic                gie_r, gie_next_s;
    logic [N_SRC-1:0]    mask_r, pend_r, pend_next_s, irq_prev_r, mode_s;
    logic [ADDR_W-1:0]   ret_r, int_vec_r;
    logic                cause_act_r;
    logic [2:0]          cause_idx_r;
    logic [DATA_W-1:0]   vec_r [N_SRC];
    logic                int_req_r, int_en_r;

    logic [3:0]          off_s;
    logic                hit_s, wr_s, start_s, ack_s, sel_found_s;
    logic [N_SRC-1:0]    avail_s, sel_oh_s, set_s, w1c_s, svc_clr_s;
    logic [2:0]          sel_idx_s;
    logic [DATA_W-1:0]   sel_vec_s, r_data_s;

`ifdef INT_LEVEL_MODE_EN
    logic [N_SRC-1:0]    mode_r;

    // Per-source trigger-mode register (1 = level-triggered).
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r <= '0;
        end else if (wr_s && (off_s == OFF_MODE)) begin
            mode_r <= w_data[N_SRC-1:0];
        end else begin
            mode_r <= mode_r;
        end
    end
    assign mode_s = mode_r;
`else
    assign mode_s = '0;
`endif

    assign off_s   = addr[3:0];
    assign hit_s   = (addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
    assign wr_s    = w_en & hit_s;
    assign avail_s = pend_r & mask_r;

    // Priority pick: scan from the top so the lowest pending index wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_oh_s    = '0;
        sel_idx_s   = 3'd0;
        sel_vec_s   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (avail_s[i]) begin
                sel_found_s = 1'b1;
                sel_oh_s    = '0;
                sel_oh_s[i] = 1'b1;
                sel_idx_s   = 3'(i);
                sel_vec_s   = vec_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pending update: sets always win over W1C and service clears, so a level
    // source stays pending while its line is high.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && gie_r && sel_found_s;
        ack_s       = wr_s && (off_s == OFF_ACK) && (state_r == ST_ACTIVE);
        set_s       = ((irq_src & ~irq_prev_r) & ~mode_s) | (irq_src & mode_s);
        w1c_s       = (wr_s && (off_s == OFF_PEND)) ? w_data[N_SRC-1:0] : '0;
        svc_clr_s   = start_s ? sel_oh_s : '0;
        pend_next_s = (pend_r & ~(w1c_s | svc_clr_s)) | set_s;
        gie_next_s  = (wr_s && (off_s == OFF_CTRL)) ? w_data[0] : gie_r;
    end

    // Service sequencer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = start_s ? ST_REQ : ST_IDLE;
            ST_REQ:    state_next_s = ST_ACTIVE;
            ST_ACTIVE: state_next_s = ack_s ? ST_IDLE : ST_ACTIVE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State, pending, control registers and registered cpu-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pend_r     <= '0;
            irq_prev_r <= '0;
            gie_r      <= 1'b0;
            mask_r     <= '0;
            int_req_r  <= 1'b0;
            int_en_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pend_r     <= pend_next_s;
            irq_prev_r <= irq_src;
            gie_r      <= gie_next_s;
            mask_r     <= (wr_s && (off_s == OFF_MASK)) ? w_data[N_SRC-1:0] : mask_r;
            int_req_r  <= (state_next_s == ST_REQ);
            int_en_r   <= (state_next_s == ST_IDLE) && gie_next_s;
        end
    end

    // Service context: cause, vector and captured return address.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_act_r <= 1'b0;
            cause_idx_r <= 3'd0;
            int_vec_r   <= '0;
            ret_r       <= '0;
        end else begin
            if (start_s) begin
                cause_act_r <= 1'b1;
                cause_idx_r <= sel_idx_s;
                int_vec_r   <= ADDR_W'(sel_vec_s);
            end else if (ack_s) begin
                cause_act_r <= 1'b0;
            end else begin
                cause_act_r <= cause_act_r;
            end
            ret_r <= (state_r == ST_REQ) ? ret_addr : ret_r;
        end
    end

    // Per-source vector registers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (reset) begin
                vec_r[i] <= '0;
            end else if (wr_s && (off_s == 4'(8 + i))) begin
                vec_r[i] <= w_data;
            end else begin
                vec_r[i] <= vec_r[i];
            end
        end
    end

    // Register-window read mux; unmapped offsets and misses read zero.
    always_comb begin
        r_data_s = '0;
        if (hit_s) begin
            case (off_s)
                OFF_CTRL:  r_data_s = DATA_W'(gie_r);
                OFF_MASK:  r_data_s = DATA_W'(mask_r);
                OFF_PEND:  r_data_s = DATA_W'(pend_r);
                OFF_RET:   r_data_s = DATA_W'(ret_r);
                OFF_CAUSE: r_data_s = DATA_W'({cause_act_r, 4'b0000, cause_idx_r});
                OFF_MODE:  r_data_s = DATA_W'(mode_s);
                default: begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (off_s == 4'(8 + i)) begin
                            r_data_s = vec_r[i];
                        end else begin
                            r_data_s = r_data_s;
                        end
                    end
                end
            endcase
        end else begin
            r_data_s = '0;
        end
    end

    assign r_data  = r_data_s;
    assign hit     = hit_s;
    assign int_req = int_req_r;
    assign int_en  = int_en_r;
    assign int_vec = int_vec_r;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_int_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] addr, w_data, r_data, ret_addr, int_vec;
    logic       w_en, hit, int_req, int_en;
    logic [3:0] irq_src;

    int errors = 0;
    int checks = 0;

    int_ctrl dut (
        .clock(clock), .reset(reset), .addr(addr), .w_data(w_data), .w_en(w_en),
        .r_data(r_data), .hit(hit), .irq_src(irq_src), .ret_addr(ret_addr),
        .int_req(int_req), .int_en(int_en), .int_vec(int_vec)
    );

    always #5 clock = ~clock;

    // Reference model: registers plus two flags "request cycle" and "in ISR".
    logic       m_gie, m_act, m_req, m_isr;
    logic [3:0] m_mask, m_pend, m_prev, m_mode;
    logic [2:0] m_idx;
    logic [7:0] m_ret, m_ivec;
    logic [7:0] m_vec [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gie = 0; m_act = 0; m_req = 0; m_isr = 0;
        m_mask = 0; m_pend = 0; m_prev = 0; m_mode = 0;
        m_idx = 0; m_ret = 0; m_ivec = 0;
        for (int i = 0; i < 4; i++) m_vec[i] = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [3:0] off;
        off = a[3:0];
        if (a[7:4] != 4'hE) return 8'h00;
        case (off)
            4'd0: return {7'd0, m_gie};
            4'd1: return {4'd0, m_mask};
            4'd2: return {4'd0, m_pend};
            4'd3: return m_ret;
            4'd4: return {m_act, 4'd0, m_idx};
            4'd6: return {4'd0, m_mode};
            4'd8, 4'd9, 4'd10, 4'd11: return m_vec[off - 4'd8];
            default: return 8'h00;
        endcase
    endfunction

    // One clock of the reference model, using the inputs the DUT just sampled.
    task automatic model_step();
        logic [3:0] set_v, w1c, svc;
        logic       wr;
        logic [3:0] off;
        int         pick;
        if (reset) begin
            model_reset();
            return;
        end
        wr  = w_en && (addr[7:4] == 4'hE);
        off = addr[3:0];
        pick = -1;
        for (int i = 0; i < 4; i++) if (pick < 0 && m_pend[i] && m_mask[i]) pick = i;
        set_v = (irq_src & ~m_prev & ~m_mode) | (irq_src & m_mode);
        w1c   = (wr && off == 4'd2) ? w_data[3:0] : 4'd0;
        svc   = 4'd0;
        if (!m_req && !m_isr) begin
            if (m_gie && pick >= 0) begin
                svc[pick] = 1'b1;
                m_act = 1'b1;
                m_idx = pick[2:0];
                m_ivec = m_vec[pick];
                m_req = 1'b1;
            end
        end else if (m_req) begin
            m_ret = ret_addr;
            m_req = 1'b0;
            m_isr = 1'b1;
        end else if (wr && off == 4'd5) begin
            m_act = 1'b0;
            m_isr = 1'b0;
        end
        m_pend = (m_pend & ~(w1c | svc)) | set_v;
        m_prev = irq_src;
        if (wr) begin
            case (off)
                4'd0: m_gie = w_data[0];
                4'd1: m_mask = w_data[3:0];
`ifdef INT_LEVEL_MODE_EN
                4'd6: m_mode = w_data[3:0];
`endif
                4'd8, 4'd9, 4'd10, 4'd11: m_vec[off - 4'd8] = w_data;
                default: ;
            endcase
        end
    endtask

    // Drive one bus cycle, check the read path, clock it, check cpu outputs.
    task automatic tick(input logic [7:0] a, input logic [7:0] wd, input logic we,
                        input logic [3:0] irq, input logic rst, output logic [7:0] rd);
        addr = a; w_data = wd; w_en = we; irq_src = irq; reset = rst;
        #1;
        rd = r_data;
        check("hit", {31'd0, hit}, {31'd0, a[7:4] == 4'hE});
        check("r_data", {24'd0, r_data}, {24'd0, model_read(a)});
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("int_req", {31'd0, int_req}, {31'd0, m_req});
        check("int_en", {31'd0, int_en}, {31'd0, !m_req && !m_isr && m_gie});
        check("int_vec", {24'd0, int_vec}, {24'd0, m_ivec});
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] wd;
        logic       we;
        logic [3:0] irq;
        logic [7:0] exp_rd;
        logic       exp_req;
        logic       exp_en;
        logic [7:0] exp_vec;
    } row_t;

    row_t tbl[$];
    logic [7:0] rd;
    int   req_count;

    initial begin
        // Setup, single service, priority, masking and set-beats-W1C vectors.
        tbl.push_back('{8'hE8, 8'h20, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hE9, 8'h40, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hEA, 8'h60, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hE1, 8'h03, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hE0, 8'h01, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h02, 1'b1, 1'b0, 8'h40});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h81, 1'b0, 1'b0, 8'h40});
        tbl.push_back('{8'hE3, 8'h00, 1'b0, 4'h0, 8'h17, 1'b0, 1'b0, 8'h40});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h40});
        tbl.push_back('{8'hE5, 8'h5A, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h01, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h3, 8'h03, 1'b1, 1'b0, 8'h20});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h80, 1'b0, 1'b0, 8'h20});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 8'h20});
        tbl.push_back('{8'hE5, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h20});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h40});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h81, 1'b0, 1'b0, 8'h40});
        tbl.push_back('{8'hE5, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE1, 8'h00, 1'b1, 4'h0, 8'h03, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h4, 8'h00, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h04, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE1, 8'h04, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h40});
        tbl.push_back('{8'hE1, 8'h00, 1'b0, 4'h0, 8'h04, 1'b1, 1'b0, 8'h60});
        tbl.push_back('{8'hE4, 8'h00, 1'b0, 4'h0, 8'h82, 1'b0, 1'b0, 8'h60});
        tbl.push_back('{8'hE2, 8'h04, 1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 8'h60});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h4, 8'h04, 1'b0, 1'b0, 8'h60});
        tbl.push_back('{8'hE5, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h60});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h04, 1'b1, 1'b0, 8'h60});
        tbl.push_back('{8'hE2, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h60});

        // Reset and register window at reset.
        reset = 1'b1; addr = 8'h00; w_data = 8'h00; w_en = 1'b0; irq_src = 4'h0; ret_addr = 8'h17;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_int_en", {31'd0, int_en}, 32'd0);
        check("reset_int_req", {31'd0, int_req}, 32'd0);
        check("reset_int_vec", {24'd0, int_vec}, 32'd0);
        for (int o = 0; o < 16; o++) begin
            tick(8'hE0 + 8'(o), 8'h00, 1'b0, 4'h0, 1'b0, rd);
            check("reset_read", {24'd0, rd}, 32'd0);
        end
        tick(8'h10, 8'h00, 1'b0, 4'h0, 1'b0, rd);
        check("miss_read", {24'd0, rd}, 32'd0);

        // Directed vector table.
        foreach (tbl[i]) begin
            tick(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].irq, 1'b0, rd);
            check($sformatf("tbl%0d_rd", i), {24'd0, rd}, {24'd0, tbl[i].exp_rd});
            check($sformatf("tbl%0d_req", i), {31'd0, int_req}, {31'd0, tbl[i].exp_req});
            check($sformatf("tbl%0d_en", i), {31'd0, int_en}, {31'd0, tbl[i].exp_en});
            check($sformatf("tbl%0d_vec", i), {24'd0, int_vec}, {24'd0, tbl[i].exp_vec});
        end

        // Reset while ACTIVE discards the service; a stale ACK is ignored.
        tick(8'hE4, 8'h00, 1'b0, 4'h0, 1'b1, rd);
        check("rst_active_req", {31'd0, int_req}, 32'd0);
        check("rst_active_en", {31'd0, int_en}, 32'd0);
        check("rst_active_vec", {24'd0, int_vec}, 32'd0);
        tick(8'hE5, 8'h00, 1'b1, 4'h0, 1'b0, rd);
        check("stale_ack_req", {31'd0, int_req}, 32'd0);
        tick(8'hE4, 8'h00, 1'b0, 4'h0, 1'b0, rd);
        check("rst_cause", {24'd0, rd}, 32'd0);
        tick(8'hE0, 8'h01, 1'b1, 4'h0, 1'b0, rd);
        check("gie_after_rst_en", {31'd0, int_en}, 32'd1);
        tick(8'hE5, 8'h00, 1'b1, 4'h0, 1'b0, rd);
        check("idle_ack_en", {31'd0, int_en}, 32'd1);

        // Offset 6 (MODE) only exists with the level-mode option.
        tick(8'hE6, 8'hFF, 1'b1, 4'h0, 1'b0, rd);
        tick(8'hE6, 8'h00, 1'b0, 4'h0, 1'b0, rd);
`ifdef INT_LEVEL_MODE_EN
        check("mode_read", {24'd0, rd}, 32'h0F);
        // Level source 0 held high is re-requested after every ACK.
        tick(8'hE6, 8'h01, 1'b1, 4'h0, 1'b0, rd);
        tick(8'hE1, 8'h01, 1'b1, 4'h0, 1'b0, rd);
        req_count = 0;
        for (int c = 0; c < 12; c++) begin
            tick((c % 4 == 3) ? 8'hE5 : 8'hE2, 8'h00, (c % 4 == 3), 4'h1, 1'b0, rd);
            if (int_req) req_count++;
        end
        check("level_rereq", {31'd0, req_count >= 2}, 32'd1);
        tick(8'hE5, 8'h00, 1'b1, 4'h0, 1'b0, rd);
        tick(8'hE2, 8'h01, 1'b1, 4'h0, 1'b0, rd);
        tick(8'hE2, 8'h00, 1'b0, 4'h0, 1'b0, rd);
        check("level_pend_clear", {24'd0, rd}, 32'd0);
        req_count = 0;
        for (int c = 0; c < 4; c++) begin
            tick(8'hE2, 8'h00, 1'b0, 4'h0, 1'b0, rd);
            if (int_req) req_count++;
        end
        check("level_no_req", req_count, 32'd0);
        tick(8'hE6, 8'h00, 1'b1, 4'h0, 1'b0, rd);
`else
        check("mode_read", {24'd0, rd}, 32'd0);
`endif

        // Randomized traffic against the reference model.
        tick(8'h00, 8'h00, 1'b0, 4'h0, 1'b1, rd);
        for (int c = 0; c < 600; c++) begin
            logic [7:0] a;
            logic       we, rst;
            ret_addr = 8'($urandom);
            a   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'hE0 | 8'($urandom_range(0, 15)));
            we  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                a = 8'hE5;
            end
            if ($urandom_range(0, 5) == 0) begin
                a  = 8'hE0;
                we = 1'b1;
            end
            rst = ($urandom_range(0, 149) == 0);
            tick(a, 8'($urandom), we, 4'($urandom), rst, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised memory-mapped interrupt controller; successor to the single-source UART interrupt wiring in the computer top level.
- Collects N_SRC interrupt sources, latches rising edges as pending, applies mask and fixed priority (lowest index wins), and drives int_req, int_en and int_vec to the cpu.
- Captures the cpu return address on entry and exposes it, the cause, per-source vectors and control through a 16-byte register window on the cpu data bus, alongside data_mem.

Parameters:
- ADDR_W, 8: data-bus address width.
- DATA_W, 8: data-bus data width.
- N_SRC, 4: interrupt source count; legal range 1..DATA_W, so N_SRC ≤ DATA_W.
- BASE_ADDR, 8'd224: window base; must be 16-aligned.

Ports:
- clock  in  1  system clock; all state updates on the posedge
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_W  bus address (cpu rs_data)
- w_data  in  DATA_W  bus write data (cpu rd_data)
- w_en  in  1  bus write strobe (cpu mem_w_en)
- r_data  out  DATA_W  combinational read data; 0 when hit=0
- hit  out  1  addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]; top level uses it to mux r_data over data_mem
- irq_src  in  N_SRC  source request lines, synchronous to clock
- ret_addr  in  ADDR_W  cpu return address
- int_req  out  1  interrupt request to cpu, one-cycle pulse
- int_en  out  1  1 when state==IDLE and GIE=1
- int_vec  out  ADDR_W  vector of the source being serviced

Behaviour:
- Register map, as offset from BASE_ADDR:
  - 0 CTRL: bit0 = GIE; RW.
  - 1 MASK: bits[N_SRC-1:0]; RW.
  - 2 PEND: read pending bits; write-1-to-clear.
  - 3 RET: captured return address; RO.
  - 4 CAUSE: bit7 = active, bits[2:0] = serviced source index; RO.
  - 5 ACK: write of any value ends the ISR; reads 0.
  - 8+i VEC[i], for i < N_SRC: RW.
  - All other offsets, and all unused bits, read 0; writes to them are ignored.
- Reset values: all registers 0; irq_prev 0; state IDLE; int_req 0; int_en 0; int_vec 0.
- Edge detect: irq_prev <= irq_src every cycle. A rising edge (irq_src & ~irq_prev) sets PEND[i].
- Same-cycle conflicts on PEND[i]:
  - Set beats a W1C clear.
  - Set beats a clear caused by servicing.
- FSM states: IDLE, REQ, ACTIVE.
- IDLE:
  - If GIE and |(PEND & MASK), select i = lowest set index.
  - Clear PEND[i]; CAUSE <= {1, i}; int_vec <= VEC[i]; go to REQ.
  - A VEC[i] write in that same cycle is not seen (old value is used).
- REQ:
  - int_req = 1 for exactly this cycle.
  - RET <= ret_addr at the end of the cycle; go to ACTIVE.
- ACTIVE:
  - int_en = 0; new edges still latch into PEND.
  - On an ACK write: CAUSE[7] <= 0; go to IDLE.
  - ACK writes in IDLE or REQ are ignored.
- Latency:
  - irq_src rises before posedge k → PEND set after k → REQ after k+1 → int_req high in cycle k+1..k+2 → RET valid after k+2.
  - Minimum spacing between back-to-back services: ACK at posedge a → IDLE after a → REQ after a+1.
- Masking:
  - A masked source still latches PEND; it is serviced once unmasked.
  - Clearing GIE while in REQ or ACTIVE does not abort the service in progress.
- An edge while the same source's PEND is already set is lost (no counting).
- A reset asserted in any state returns to the reset values at the next posedge; any in-progress service is discarded.

Optional Feature:
- Macro: INT_LEVEL_MODE_EN.
- When defined:
  - Adds MODE at offset 6 (RW, bits[N_SRC-1:0], reset 0).
  - MODE[i]=1 makes source i level-triggered: PEND[i] is set every cycle irq_src[i]=1.
  - W1C and service clears only take effect once the line is low.
  - MODE[i]=0 keeps edge behaviour.
- When undefined: offset 6 reads 0; writes are ignored; all sources are edge-triggered.

Test Plan:
- Reset, then read every offset → all 0; int_en=0, int_req=0.
- Setup: write VEC[1]=8'h40, MASK=8'h03, CTRL=1, ret_addr=8'h17; pulse irq_src[1] → int_req high for 1 cycle exactly 2 cycles after the edge; int_vec=8'h40; RET=8'h17; CAUSE=8'h81; int_en=0 until ACK, then 1.
- Priority: raise irq_src[0] and irq_src[1] in the same cycle with both unmasked → source 0 serviced first (CAUSE=8'h80); after ACK, source 1 serviced (CAUSE=8'h81) 2 cycles later.
- Masking: MASK=8'h00, pulse irq_src[2] → PEND=8'h04, no int_req. Write MASK=8'h04 → int_req follows. Write PEND=8'h04 with a simultaneous new edge on source 2 → PEND[2] stays 1.
- Reset during ACTIVE → state IDLE, CAUSE=0, int_vec=0, no int_req; a stale ACK is ignored.
- With INT_LEVEL_MODE_EN: MODE=8'h01, hold irq_src[0]=1 → re-requested after each ACK; after the line drops and PEND is W1C'd → PEND=0, no further requests.
